// File: rtl/dmem_pkg.sv
// Shared encodings and helper functions for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Byte lanes touched by an access of the given size at the given word offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = 4'b0011 << off;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_X) ||
           ((size == SZ_H) && off[0]) ||
           ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised backing store: byte-lane write enables, combinational read.
module dmem_array #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic [3:0]            we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with fixed access latency, lane-merged stores and
// right-aligned zero-filled load data.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [3:0]            resp_strb,
  output logic                  resp_err
);

  localparam int unsigned IW    = DEPTH_LOG2 + 2;
  localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic [IW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [3:0]            strb_q;
  logic                  err_q;

  logic                  acc_we;
  logic [1:0]            acc_size;
  logic [IW-1:0]         acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [1:0]            off;
  logic                  acc_err;
  logic                  accept;
  logic                  enter_resp;
  logic [3:0]            arr_we;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic [DATA_WIDTH-1:0] ld_shift;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  unused_addr;

  assign unused_addr = ^req_addr[ADDR_WIDTH-1:IW];

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With LATENCY == 1 the access happens on the accept edge itself, so the
  // array must see the live request rather than the not-yet-latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_size  = req_size;
      acc_addr  = req_addr[IW-1:0];
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign off        = acc_addr[1:0];
  assign acc_err    = access_err(acc_size, off);
  assign enter_resp = ((state_q == WAIT) && (cnt_q == '0)) || (accept && (LATENCY == 1));
  assign arr_we     = (enter_resp && acc_we && !acc_err && !rst) ? lane_mask(acc_size, off) : '0;
  assign arr_wdata  = acc_wdata << {off, 3'b000};
  assign ld_shift   = arr_rdata >> {off, 3'b000};

  always_comb begin
    ld_data = '0;
    case (acc_size)
      SZ_B:    ld_data[7:0]  = ld_shift[7:0];
      SZ_H:    ld_data[15:0] = ld_shift[15:0];
      default: ld_data       = ld_shift;
    endcase
  end

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (clk),
    .we_i   (arr_we),
    .addr_i (acc_addr[IW-1:2]),
    .wdata_i(arr_wdata),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr[IW-1:0];
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      strb_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        err_q        <= acc_err;
        rdata_q      <= (acc_we || acc_err) ? '0 : ld_data;
        strb_q       <= (acc_we || acc_err) ? 4'b0000 : lane_mask(acc_size, 2'b00);
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_strb  = strb_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three latency variants share the request inputs;
// only the selected one is out of reset and observed.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_v [3];
  logic        req_valid, req_we, resp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic [2:0]  rdy, vld, errs;
  logic [31:0] rdt [3];
  logic [3:0]  stb [3];

  int          sel;
  logic        m_ready, m_valid, m_err;
  logic [31:0] m_rdata;
  logic [3:0]  m_strb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst_v[0]), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vld[0]),
    .resp_ready(resp_ready), .resp_rdata(rdt[0]), .resp_strb(stb[0]), .resp_err(errs[0]));

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst_v[1]), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vld[1]),
    .resp_ready(resp_ready), .resp_rdata(rdt[1]), .resp_strb(stb[1]), .resp_err(errs[1]));

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst_v[2]), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vld[2]),
    .resp_ready(resp_ready), .resp_rdata(rdt[2]), .resp_strb(stb[2]), .resp_err(errs[2]));

  always_comb begin
    m_ready = rdy[sel];
    m_valid = vld[sel];
    m_err   = errs[sel];
    m_rdata = rdt[sel];
    m_strb  = stb[sel];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction. lat counts cycles from the handshake cycle to the
  // first cycle with resp_valid high.
  task automatic do_req(input bit we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic [3:0] st, output logic e, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
    resp_ready = 1'b0;
    n = 0;
    while (!m_ready && n < 50) begin @(negedge clk); n++; end
    if (!m_ready) chk("accept_timeout", 32'(m_ready), 32'd1);
    lat = 0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 50) begin @(negedge clk); lat++; end
    rd = m_rdata; st = m_strb; e = m_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  strb;
    bit          err;
  } vec_t;

  logic [7:0] mm [int];

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd, a, wd, exp_rd;
    logic [3:0]  st, exp_st;
    logic        e, exp_e;
    int          lat, nb, b, cnt;
    bit          we;
    logic [1:0]  sz;
    int          acc_c[$];
    logic [31:0] exp_q[$];
    logic [31:0] saddr[4];
    int          issued, got;
    bit          pending;

    sel = 0;
    rst_v[0] = 1'b1; rst_v[1] = 1'b1; rst_v[2] = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd0);
      chk($sformatf("rst_valid%0d", k), 32'(vld[k]), 32'd0);
      chk($sformatf("rst_rdata%0d", k), rdt[k], 32'd0);
      chk($sformatf("rst_strb%0d", k), 32'(stb[k]), 32'd0);
      chk($sformatf("rst_err%0d", k), 32'(errs[k]), 32'd0);
    end
    rst_v[0] = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(m_ready), 32'd1);

    vecs.push_back('{1, 2'd2, 32'h10, 32'hDEADBEEF, 32'h0, 4'h0, 0});
    vecs.push_back('{0, 2'd2, 32'h10, 32'h0, 32'hDEADBEEF, 4'hF, 0});
    vecs.push_back('{1, 2'd0, 32'h13, 32'h0000005A, 32'h0, 4'h0, 0});
    vecs.push_back('{0, 2'd2, 32'h10, 32'h0, 32'h5AADBEEF, 4'hF, 0});
    vecs.push_back('{0, 2'd0, 32'h12, 32'h0, 32'h000000AD, 4'h1, 0});
    vecs.push_back('{0, 2'd1, 32'h11, 32'h0, 32'h0, 4'h0, 1});
    vecs.push_back('{1, 2'd2, 32'h12, 32'h12345678, 32'h0, 4'h0, 1});
    vecs.push_back('{0, 2'd2, 32'h10, 32'h0, 32'h5AADBEEF, 4'hF, 0});
    vecs.push_back('{1, 2'd2, 32'h14, 32'h01020304, 32'h0, 4'h0, 0});
    vecs.push_back('{1, 2'd1, 32'h16, 32'hFFFFABCD, 32'h0, 4'h0, 0});
    vecs.push_back('{0, 2'd2, 32'h14, 32'h0, 32'hABCD0304, 4'hF, 0});
    vecs.push_back('{0, 2'd1, 32'h14, 32'h0, 32'h00000304, 4'h3, 0});
    vecs.push_back('{0, 2'd0, 32'h17, 32'h0, 32'h000000AB, 4'h1, 0});
    vecs.push_back('{0, 2'd3, 32'h14, 32'h0, 32'h0, 4'h0, 1});
    vecs.push_back('{1, 2'd0, 32'h10000015, 32'hFFFFFF77, 32'h0, 4'h0, 0});
    vecs.push_back('{0, 2'd2, 32'h80000014, 32'h0, 32'hABCD7704, 4'hF, 0});
    vecs.push_back('{1, 2'd1, 32'h15, 32'hFFFF, 32'h0, 4'h0, 1});
    vecs.push_back('{0, 2'd1, 32'h16, 32'h0, 32'h0000ABCD, 4'h3, 0});
    vecs.push_back('{1, 2'd3, 32'h14, 32'h0, 32'h0, 4'h0, 1});
    vecs.push_back('{0, 2'd2, 32'h14, 32'h0, 32'hABCD7704, 4'hF, 0});

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wdata, rd, st, e, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("vec%0d_strb", i), 32'(st), 32'(vecs[i].strb));
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
    end

    // Response held under back-pressure while a new request waits.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
    chk("stall_acc_ready", 32'(m_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("stall_first_valid", 32'(m_valid), 32'd1);
    req_valid = 1'b1; req_size = 2'd0; req_addr = 32'h12;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_rdata", m_rdata, 32'h5AADBEEF);
      chk("stall_strb", 32'(m_strb), 32'hF);
      chk("stall_ready", 32'(m_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("stall_release_ready", 32'(m_ready), 32'd1);
    chk("stall_release_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("stall_second_taken", 32'(m_ready), 32'd0);
    @(negedge clk);
    chk("stall_second_valid", 32'(m_valid), 32'd1);
    chk("stall_second_rdata", m_rdata, 32'h000000AD);
    chk("stall_second_strb", 32'(m_strb), 32'h1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Randomised traffic against a byte-level model over an aliased window.
    for (int w = 0; w < 16; w++) begin
      a = 32'h40 + 32'(4 * w);
      wd = $urandom;
      do_req(1'b1, 2'd2, a, wd, rd, st, e, lat);
      for (int i = 0; i < 4; i++) mm[int'(a) + i] = wd[8*i +: 8];
    end
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom & 32'hFFFF_F000) | (32'h40 + 32'($urandom_range(0, 63)));
      wd = $urandom;
      b  = int'(a & 32'hFFF);
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      exp_e  = (sz == 2'd3) || (sz == 2'd1 && (b % 2) != 0) || (sz == 2'd2 && (b % 4) != 0);
      exp_rd = '0;
      exp_st = '0;
      if (!exp_e && we) begin
        for (int i = 0; i < nb; i++) mm[b + i] = wd[8*i +: 8];
      end else if (!exp_e) begin
        for (int i = 0; i < nb; i++) exp_rd = exp_rd | (32'(mm[b + i]) << (8 * i));
        exp_st = 4'((1 << nb) - 1);
      end
      do_req(we, sz, a, wd, rd, st, e, lat);
      chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
      chk($sformatf("rnd%0d_strb", n), 32'(st), 32'(exp_st));
      chk($sformatf("rnd%0d_err", n), 32'(e), 32'(exp_e));
      chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'd2);
    end

    // LATENCY=3: reset while a store is still waiting must discard it.
    @(negedge clk);
    rst_v[0] = 1'b1; sel = 1; rst_v[1] = 1'b0;
    do_req(1'b1, 2'd2, 32'h20, 32'hCAFEF00D, rd, st, e, lat);
    chk("l3_store_lat", 32'(lat), 32'd3);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'h11111111;
    chk("l3_rst_acc_ready", 32'(m_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    rst_v[1] = 1'b1;
    @(negedge clk);
    rst_v[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_valid) cnt++;
      @(negedge clk);
    end
    chk("l3_no_resp_after_rst", 32'(cnt), 32'd0);
    do_req(1'b0, 2'd2, 32'h20, 32'h0, rd, st, e, lat);
    chk("l3_prior_contents", rd, 32'hCAFEF00D);
    chk("l3_load_lat", 32'(lat), 32'd3);

    // LATENCY=1: streamed loads with the consumer always ready.
    @(negedge clk);
    rst_v[1] = 1'b1; sel = 2; rst_v[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      saddr[i] = 32'h100 + 32'(8 * i);
      wd = $urandom;
      exp_q.push_back(wd);
      do_req(1'b1, 2'd2, saddr[i], wd, rd, st, e, lat);
      chk($sformatf("l1_store%0d_lat", i), 32'(lat), 32'd1);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = saddr[0];
    resp_ready = 1'b1;
    issued = 0; got = 0; pending = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (pending) begin
        pending = 1'b0;
        issued++;
        if (issued < 4) req_addr = saddr[issued];
        else req_valid = 1'b0;
      end
      if (m_valid) begin
        chk($sformatf("l1_stream%0d_rdata", got), m_rdata, exp_q[got]);
        got++;
      end
      if (req_valid && m_ready) begin
        acc_c.push_back(c);
        pending = 1'b1;
      end
    end
    resp_ready = 1'b0;
    req_valid = 1'b0;
    chk("l1_stream_count", 32'(got), 32'd4);
    chk("l1_accept_count", 32'(acc_c.size()), 32'd4);
    for (int i = 1; i < acc_c.size(); i++)
      chk($sformatf("l1_accept_gap%0d", i), 32'(acc_c[i] - acc_c[i-1]), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
